// File: rtl/speed_table_arbiter.sv
// speed_table_arbiter
// Round-robin arbiter sharing one single-port, fixed-latency speed-profile
// RAM between several step-motor channels. One read is granted per cycle.
// A tag pipe follows each read through the RAM latency, and the data is
// returned to its channel with a one-cycle strobe on a shared data bus.
// Each channel has at most one read outstanding at any time.

module speed_table_arbiter #(
  parameter int C_MOTOR_NBR           = 4,
  parameter int C_SPEED_ADDRESS_WIDTH = 9,
  parameter int C_SPEED_DATA_WIDTH    = 16,
  parameter int C_RD_LATENCY          = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [C_MOTOR_NBR-1:0]                       i_req,
  input  logic [C_MOTOR_NBR*C_SPEED_ADDRESS_WIDTH-1:0] i_addr,
  output logic [C_MOTOR_NBR-1:0]                       o_gnt,
  output logic                                         o_rd_en,
  output logic [C_SPEED_ADDRESS_WIDTH-1:0]             o_rd_addr,
  input  logic [C_SPEED_DATA_WIDTH-1:0]                i_rd_data,
  output logic [C_MOTOR_NBR-1:0]                       o_rvalid,
  output logic [C_SPEED_DATA_WIDTH-1:0]                o_rdata,
  output logic                                         o_busy
);

  localparam int C_IDX_W = (C_MOTOR_NBR > 1) ? $clog2(C_MOTOR_NBR) : 1;

  // Channel index, and one extra bit so that ptr + offset cannot overflow
  // before it is wrapped back into range.
  typedef logic [C_IDX_W-1:0] idx_t;
  typedef logic [C_IDX_W:0]   cand_t;

  // Arbitration state
  logic [C_MOTOR_NBR-1:0]           r_gnt;
  logic                             r_rd_en;
  logic [C_SPEED_ADDRESS_WIDTH-1:0] r_rd_addr;
  idx_t                             r_ptr;
  logic [C_MOTOR_NBR-1:0]           r_pending;
  logic                             r_busy;

  // Tag pipe: one stage per cycle of RAM latency
  logic                             r_tag_vld [C_RD_LATENCY];
  idx_t                             r_tag_idx [C_RD_LATENCY];

  // Return path
  logic [C_MOTOR_NBR-1:0]           r_rvalid;
  logic [C_SPEED_DATA_WIDTH-1:0]    r_rdata;

  // Combinational helpers
  logic [C_SPEED_ADDRESS_WIDTH-1:0] w_addr [C_MOTOR_NBR];
  logic [C_MOTOR_NBR-1:0]           w_eligible;
  logic                             w_found;
  idx_t                             w_win;
  cand_t                            w_cand;
  logic [C_MOTOR_NBR-1:0]           w_gnt_onehot;
  logic                             w_ret_vld;
  idx_t                             w_ret_idx;
  logic [C_MOTOR_NBR-1:0]           w_ret_onehot;
  logic [C_MOTOR_NBR-1:0]           w_pending_nxt;

  // Unpack the flat address bus into one address per channel.
  for (genvar g = 0; g < C_MOTOR_NBR; g++) begin : g_addr
    assign w_addr[g] = i_addr[g*C_SPEED_ADDRESS_WIDTH +: C_SPEED_ADDRESS_WIDTH];
  end

  // Round-robin search: the first eligible channel after the last winner.
  always_comb begin
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    w_eligible   = i_req & ~r_pending;
    w_found      = 1'b0;
    w_win        = r_ptr;
    w_cand       = '0;
    w_gnt_onehot = '0;
    for (int i = 1; i <= C_MOTOR_NBR; i++) begin
      w_cand = cand_t'(r_ptr) + cand_t'(i);
      if (w_cand >= cand_t'(C_MOTOR_NBR)) begin
        w_cand = w_cand - cand_t'(C_MOTOR_NBR);
      end
      if (!w_found && w_eligible[idx_t'(w_cand)]) begin
        w_found = 1'b1;
        w_win   = idx_t'(w_cand);
      end
    end
    w_gnt_onehot[w_win] = w_found;
  end

  // Decode the tag at the end of the pipe; the RAM data is valid this cycle.
  always_comb begin
    w_ret_vld               = r_tag_vld[C_RD_LATENCY-1];
    w_ret_idx               = r_tag_idx[C_RD_LATENCY-1];
    w_ret_onehot            = '0;
    w_ret_onehot[w_ret_idx] = w_ret_vld;
    // A channel is never granted while pending, so set and clear of the same
    // bit can never coincide.
    w_pending_nxt           = (r_pending | w_gnt_onehot) & ~w_ret_onehot;
  end

  // Register the grant, the RAM read port and the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_gnt     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_ptr     <= idx_t'(C_MOTOR_NBR - 1);
    end else begin
      r_gnt   <= w_gnt_onehot;
      r_rd_en <= w_found;
      if (w_found) begin
        r_rd_addr <= w_addr[w_win];
        r_ptr     <= w_win;
      end
    end
  end

  // Track per-channel outstanding reads and the aggregate busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_busy    <= |w_pending_nxt;
    end
  end

  // Shift the {valid, index} tag alongside the RAM read latency. While
  // o_rd_en is high r_ptr holds the channel just granted, so it is the tag.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the tag pipe is a handful of flops, not a RAM, and must be cleared
    // so that reads in flight at reset never produce a return strobe.
    if (reset) begin
      for (int s = 0; s < C_RD_LATENCY; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= r_rd_en;
      r_tag_idx[0] <= r_ptr;
      for (int s = 1; s < C_RD_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  // Capture returning RAM data and strobe the owning channel for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_ret_onehot;
      if (w_ret_vld) begin
        r_rdata <= i_rd_data;
      end
    end
  end

  assign o_gnt     = r_gnt;
  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_speed_table_arbiter.sv
// tb_speed_table_arbiter
// Directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model (FIFO of in-flight reads with due edges) predicts
// every output each cycle; a RAM model with fixed latency feeds i_rd_data.

module tb_speed_table_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int L  = 2;

  logic              clk;
  logic              reset;
  logic [N-1:0]      i_req;
  logic [N*AW-1:0]   i_addr;
  logic [N-1:0]      o_gnt;
  logic              o_rd_en;
  logic [AW-1:0]     o_rd_addr;
  logic [DW-1:0]     i_rd_data;
  logic [N-1:0]      o_rvalid;
  logic [DW-1:0]     o_rdata;
  logic              o_busy;

  logic [AW-1:0]     tb_addr [N];
  logic [DW-1:0]     ram [2**AW];
  logic [DW-1:0]     rd_pipe [L];

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  speed_table_arbiter #(
    .C_MOTOR_NBR          (N),
    .C_SPEED_ADDRESS_WIDTH(AW),
    .C_SPEED_DATA_WIDTH   (DW),
    .C_RD_LATENCY         (L)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .o_gnt    (o_gnt),
    .o_rd_en  (o_rd_en),
    .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data),
    .o_rvalid (o_rvalid),
    .o_rdata  (o_rdata),
    .o_busy   (o_busy)
  );

  for (genvar g = 0; g < N; g++) begin : g_addr
    assign i_addr[g*AW +: AW] = tb_addr[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data for an enabled read appears L cycles later; garbage otherwise.
  always @(posedge clk) begin
    rd_pipe[0] <= o_rd_en ? ram[o_rd_addr] : DW'($urandom);
    for (int s = 1; s < L; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign i_rd_data = rd_pipe[L-1];

  // ---------------- behavioural model ----------------
  typedef struct {
    int          ch;
    logic [DW-1:0] data;
    int          due;
  } rd_t;

  rd_t           inflight [$];
  logic [N-1:0]  m_pend;
  int            m_ptr;
  int            edge_n = 0;
  logic [N-1:0]  e_gnt, e_rvalid;
  logic          e_rd_en, e_busy;
  logic [AW-1:0] e_rd_addr;
  logic [DW-1:0] e_rdata;

  task automatic model_reset();
    inflight.delete();
    m_pend    = '0;
    m_ptr     = N - 1;
    e_gnt     = '0;
    e_rvalid  = '0;
    e_rd_en   = 1'b0;
    e_busy    = 1'b0;
    e_rd_addr = '0;
    e_rdata   = '0;
  endtask

  task automatic model_step();
    int  win;
    int  c;
    rd_t rd;
    edge_n++;
    win = -1;
    for (int i = 1; i <= N; i++) begin
      c = (m_ptr + i) % N;
      if (win < 0 && i_req[c] && !m_pend[c]) win = c;
    end
    e_rvalid = '0;
    if (inflight.size() > 0 && inflight[0].due == edge_n) begin
      rd = inflight.pop_front();
      e_rvalid[rd.ch] = 1'b1;
      e_rdata         = rd.data;
      m_pend[rd.ch]   = 1'b0;
    end
    e_gnt   = '0;
    e_rd_en = 1'b0;
    if (win >= 0) begin
      e_gnt[win]  = 1'b1;
      e_rd_en     = 1'b1;
      e_rd_addr   = tb_addr[win];
      m_pend[win] = 1'b1;
      m_ptr       = win;
      rd.ch       = win;
      rd.data     = ram[tb_addr[win]];
      rd.due      = edge_n + L + 1;
      inflight.push_back(rd);
    end
    e_busy = |m_pend;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_gnt",     o_gnt,     e_gnt);
        check("cyc_rd_en",   o_rd_en,   e_rd_en);
        check("cyc_rd_addr", o_rd_addr, e_rd_addr);
        check("cyc_rvalid",  o_rvalid,  e_rvalid);
        check("cyc_rdata",   o_rdata,   e_rdata);
        check("cyc_busy",    o_busy,    e_busy);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    i_req = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},     o_gnt,     '0);
    check({tag, "_rd_en"},   o_rd_en,   '0);
    check({tag, "_rd_addr"}, o_rd_addr, '0);
    check({tag, "_rvalid"},  o_rvalid,  '0);
    check({tag, "_rdata"},   o_rdata,   '0);
    check({tag, "_busy"},    o_busy,    '0);
  endtask

  // Single read of RAM[5] by channel 0 with hand-computed timing.
  task automatic single_read(input string tag);
    tb_addr[0] = 9'h005;
    i_req      = 4'b0001;
    tick();
    check({tag, "_gnt"},       o_gnt,     4'b0001);
    check({tag, "_model_gnt"}, e_gnt,     4'b0001);
    check({tag, "_rd_en"},     o_rd_en,   1'b1);
    check({tag, "_rd_addr"},   o_rd_addr, 9'h005);
    check({tag, "_busy1"},     o_busy,    1'b1);
    i_req = '0;
    tick();
    check({tag, "_rvalid_e2"}, o_rvalid,  4'b0000);
    check({tag, "_busy2"},     o_busy,    1'b1);
    tick();
    check({tag, "_rvalid_e3"}, o_rvalid,  4'b0000);
    check({tag, "_busy3"},     o_busy,    1'b1);
    tick();
    check({tag, "_rvalid"},    o_rvalid,  4'b0001);
    check({tag, "_rdata"},     o_rdata,   16'h1234);
    check({tag, "_busy_off"},  o_busy,    1'b0);
    tick();
    check({tag, "_rvalid_off"}, o_rvalid, 4'b0000);
    check({tag, "_rdata_hold"}, o_rdata,  16'h1234);
  endtask

  initial begin
    int cnt;
    int bad;
    reset = 1'b1;
    i_req = '0;
    for (int k = 0; k < N; k++) tb_addr[k] = '0;
    for (int a = 0; a < 2**AW; a++) ram[a] = DW'($urandom);
    ram[5] = 16'h1234;
    ram[1] = 16'hA001;
    ram[2] = 16'hB002;
    ram[3] = 16'hC003;
    ram[4] = 16'hD004;
    cmp_en = 1'b1;
    tick(2);
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // 1. single read
    single_read("s1");

    // 2. all four channels from reset, addresses 1..4
    do_reset();
    for (int k = 0; k < N; k++) tb_addr[k] = AW'(k + 1);
    i_req = 4'b1111;
    for (int i = 1; i <= 7; i++) begin
      logic [3:0] eg, er;
      tick();
      eg = (i <= 4) ? 4'(1 << (i - 1)) : 4'b0000;
      er = (i >= 4) ? 4'(1 << (i - 4)) : 4'b0000;
      check("s2_gnt_order",    o_gnt,    eg);
      check("s2_rvalid_order", o_rvalid, er);
      if (i >= 4) check("s2_rdata", o_rdata, ram[i - 3]);
      if (i <= 4) i_req[i - 1] = 1'b0;
    end
    tick(2);

    // 3. rotation: serve channel 2, then 1 and 3 together -> 3 first
    tb_addr[2] = 9'h007;
    i_req      = 4'b0100;
    tick();
    check("s3_gnt2", o_gnt, 4'b0100);
    i_req = '0;
    tick(4);
    tb_addr[1] = 9'h008;
    tb_addr[3] = 9'h009;
    i_req      = 4'b1010;
    tick();
    check("s3_first_ch3", o_gnt, 4'b1000);
    i_req[3] = 1'b0;
    tick();
    check("s3_then_ch1", o_gnt, 4'b0010);
    i_req[1] = 1'b0;
    tick(5);

    // 4. held request on channel 1 for 20 cycles
    tb_addr[1] = 9'h011;
    i_req      = 4'b0010;
    cnt        = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_gnt[1]) cnt++;
    end
    check("s4_grant_count", cnt, (20 - 1) / (L + 2) + 1);
    i_req = '0;
    tick(6);

    // 5. channel 0 withdraws while channel 3 wins
    tb_addr[0] = 9'h003;
    tb_addr[3] = 9'h00A;
    i_req      = 4'b1001;
    tick();
    check("s5_gnt3", o_gnt, 4'b1000);
    i_req = '0;
    bad   = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_gnt[0] || o_rvalid[0]) bad++;
    end
    check("s5_no_ch0_activity", bad, 0);

    // 6. reset mid-flight
    tb_addr[0] = 9'h005;
    i_req      = 4'b0001;
    tick();
    check("s6_gnt", o_gnt, 4'b0001);
    i_req = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("s6_async");
    tick(2);
    reset = 1'b0;
    bad   = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_rvalid != '0) bad++;
    end
    check("s6_no_stale_rvalid", bad, 0);
    single_read("s6_after");

    // Randomized traffic honouring the request protocol.
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (!i_req[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            tb_addr[k] = AW'($urandom);
            i_req[k]   = 1'b1;
          end
        end else if (e_gnt[k]) begin
          if ($urandom_range(0, 1) == 0) i_req[k] = 1'b0;
          else tb_addr[k] = AW'($urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          i_req[k] = 1'b0;
        end
      end
    end
    i_req = '0;
    tick(10);
    check("rand_drain_busy", o_busy, 1'b0);
    check("rand_drain_gnt",  o_gnt,  '0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/speed_table_arbiter.md
Name: speed_table_arbiter

Overview:
- Shares one speed-profile block RAM (single read port, fixed read latency) between C_MOTOR_NBR step-motor channels.
- Each channel raises a read request with an address. The arbiter grants one channel per cycle in round-robin order and drives the RAM read port.
- It tracks each issued read through the RAM latency and returns the data to the requesting channel with a one-cycle valid strobe.
- It replaces fixed time-slot RAM sharing, so idle channels no longer waste read slots.

Parameters:
- C_MOTOR_NBR, 4, number of requesting channels (>= 2).
- C_SPEED_ADDRESS_WIDTH, 9, RAM address width.
- C_SPEED_DATA_WIDTH, 16, RAM data width.
- C_RD_LATENCY, 2, cycles from o_rd_en high to i_rd_data valid (>= 1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  C_MOTOR_NBR  per-channel read request, level.
- i_addr  in  C_MOTOR_NBR*C_SPEED_ADDRESS_WIDTH  per-channel address; channel k occupies bits [k*AW +: AW].
- o_gnt  out  C_MOTOR_NBR  one-hot grant pulse, one cycle.
- o_rd_en  out  1  RAM read enable.
- o_rd_addr  out  C_SPEED_ADDRESS_WIDTH  RAM read address.
- i_rd_data  in  C_SPEED_DATA_WIDTH  RAM read data.
- o_rvalid  out  C_MOTOR_NBR  one-hot return strobe, one cycle.
- o_rdata  out  C_SPEED_DATA_WIDTH  returned data, shared bus, qualified by o_rvalid.
- o_busy  out  1  any read outstanding.

Behaviour:
- Reset (async assert, sync release): o_gnt=0, o_rd_en=0, o_rd_addr=0, o_rvalid=0, o_rdata=0, o_busy=0, pending=0, tag pipe cleared, rr pointer = C_MOTOR_NBR-1, so channel 0 has first priority.
- Eligibility: eligible[k] = i_req[k] & ~pending[k]. Only one read may be outstanding per channel.
- Arbitration each cycle:
  - Search eligible starting at (ptr+1) mod C_MOTOR_NBR, wrapping. The first hit is the winner w.
  - Registered outputs: o_gnt[w]=1, o_rd_en=1, o_rd_addr=i_addr[w], pending[w]<=1, ptr<=w.
  - No eligible channel: o_gnt=0, o_rd_en=0, o_rd_addr holds its last value, ptr holds.
- Throughput: at most one grant per cycle; back-to-back grants to different channels are allowed.
- Tag pipeline: a shift register of depth C_RD_LATENCY carries {valid, index w} aligned with o_rd_en.
- Return path: when the tag emerges at the pipe end, i_rd_data is valid in that cycle. On the next edge, o_rdata<=i_rd_data, o_rvalid[w]<=1 for one cycle, and pending[w]<=0.
- o_rdata holds its value when o_rvalid=0.
- Latency: i_req rises at edge t with the arbiter idle → o_gnt/o_rd_en high after edge t+1 → o_rvalid high after edge t+1+C_RD_LATENCY+1, i.e. C_RD_LATENCY+2 edges after the request.
- Request protocol:
  - i_addr[k] must be stable from i_req[k] high until o_gnt[k]; it is sampled at grant.
  - The requester may drop i_req any cycle before grant; the request is then withdrawn with no effect.
  - Holding i_req high after grant requests another read. It becomes eligible again the cycle after its o_rvalid, and round-robin order still applies.
- Same-cycle clear and re-grant: pending clears on the edge that asserts o_rvalid, so a channel still holding i_req can be granted on the following edge. No same-edge grant-while-pending is allowed.
- Fairness: a continuously eligible channel is granted within C_MOTOR_NBR cycles.
- o_busy = |pending, registered.
- Reset mid-operation: all in-flight reads are dropped; no o_rvalid is produced for them after reset release.
- Single requester: it receives one read every C_RD_LATENCY+2 cycles at most. This is not a bug; channels pipeline across each other.

Test Plan:
1. Single read: i_req=4'b0001, i_addr[0]=9'h005, C_RD_LATENCY=2, RAM[5]=16'h1234 → o_gnt=0001 and o_rd_addr=5 one cycle later; o_rvalid=0001 with o_rdata=16'h1234 four edges after the request; o_busy high for exactly those cycles.
2. All four channels request simultaneously from reset with addresses 1,2,3,4 → grants on consecutive cycles in order 0,1,2,3; o_rvalid returns in the same order with RAM[1..4], one per cycle.
3. Round-robin rotation: after channel 2 is served, channels 1 and 3 request together → channel 3 is granted first, then 1.
4. Held request: channel 1 holds i_req high for 20 cycles, others idle → exactly one o_gnt[1] per C_RD_LATENCY+2 cycles; never two outstanding.
5. Withdraw: channel 0 pulses i_req for one cycle while channel 3 is being granted that cycle → no grant to channel 0 afterward, and no o_rvalid[0].
6. Reset mid-flight: assert reset one cycle after a grant → all outputs are 0 immediately (async); no o_rvalid after release; the next request behaves as in scenario 1.
